// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle core's multiply/divide unit.
// Contents:
//   OP_MULT/OP_MULTU/OP_DIV/OP_DIVU : 2-bit op encodings presented on op
//   state_e                         : FSM states of mc_muldiv_unit
//   CNT_W                           : iteration-counter width for the default 32-bit unit
//   cnt_width()                     : iteration-counter width for any WIDTH
package mc_pkg;

   // op[1] selects divide, op[0] selects the unsigned variant.
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int WIDTH_DEFAULT = 32;
   localparam int CNT_W         = $clog2(WIDTH_DEFAULT + 1);

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/mc_sign_fix.sv
// Conditional two's-complement negate.
// Ports:
//   din  : input  value
//   neg  : negate din when high, pass it through otherwise
//   dout : result (modulo 2^W)
module mc_sign_fix
   import mc_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [W-1:0] din,
   input  logic         neg,
   output logic [W-1:0] dout
);

   assign dout = neg ? (~din + 1'b1) : din;

endmodule

// File: rtl/mc_muldiv_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) owning HI/LO.
// Operands are converted to magnitudes on acceptance, an unsigned core runs
// for WIDTH cycles, and a single FIX cycle applies the sign correction.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   start    : operation request, honoured only in IDLE
//   op       : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b     : multiplicand/dividend, multiplier/divisor (sampled with start)
//   hi_we    : MTHI write enable (IDLE, no start)
//   lo_we    : MTLO write enable (IDLE, no start)
//   wdata    : MTHI/MTLO data
//   busy     : operation in progress
//   done     : one-cycle completion pulse, hi/lo valid
//   div_zero : sticky divide-by-zero flag, cleared by the next accepted start
//   hi, lo   : HI/LO registers
module mc_muldiv_unit
   import mc_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CALC_CNT_W = cnt_width(WIDTH);

   state_e                  state;
   logic [CALC_CNT_W-1:0]   cnt;

   // Operation context captured at acceptance
   logic [1:0]              op_q;
   logic                    sign_a;
   logic                    sign_b;
   logic                    b_zero;
   logic [WIDTH-1:0]        a_orig;
   logic [WIDTH-1:0]        opnd;     // |a| for multiply, |b| (divisor) for divide
   logic [WIDTH-1:0]        acc_hi;   // product high half / partial remainder
   logic [WIDTH-1:0]        acc_lo;   // multiplier bits / dividend-then-quotient bits

   logic [WIDTH-1:0]        abs_a;
   logic [WIDTH-1:0]        abs_b;
   logic [WIDTH:0]          mul_sum;
   logic [WIDTH:0]          div_shift;
   logic                    div_ok;
   logic [WIDTH-1:0]        div_rem;
   logic                    neg_res;
   logic                    neg_rem;
   logic [2*WIDTH-1:0]      prod_fixed;
   logic [WIDTH-1:0]        quot_fixed;
   logic [WIDTH-1:0]        rem_fixed;

   mc_sign_fix #(.W(WIDTH)) u_abs_a (
      .din  (a),
      .neg  (~op[0] & a[WIDTH-1]),
      .dout (abs_a)
   );

   mc_sign_fix #(.W(WIDTH)) u_abs_b (
      .din  (b),
      .neg  (~op[0] & b[WIDTH-1]),
      .dout (abs_b)
   );

   // Shift-add step: the carry out of the high half becomes the new MSB
   // when the accumulator shifts right.
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

   // Restoring step: the partial remainder is always below the divisor, so a
   // successful subtraction always fits back into WIDTH bits.
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_ok    = (div_shift >= {1'b0, opnd});
   assign div_rem   = div_shift[WIDTH-1:0] - opnd;

   assign neg_res   = ~op_q[0] & (sign_a ^ sign_b);
   assign neg_rem   = ~op_q[0] & sign_a;

   mc_sign_fix #(.W(2*WIDTH)) u_prod_fix (
      .din  ({acc_hi, acc_lo}),
      .neg  (neg_res),
      .dout (prod_fixed)
   );

   mc_sign_fix #(.W(WIDTH)) u_quot_fix (
      .din  (acc_lo),
      .neg  (neg_res),
      .dout (quot_fixed)
   );

   mc_sign_fix #(.W(WIDTH)) u_rem_fix (
      .din  (acc_hi),
      .neg  (neg_rem),
      .dout (rem_fixed)
   );

   // Datapath: operand capture and one iteration per CALC cycle
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && start) begin
         op_q   <= op;
         sign_a <= ~op[0] & a[WIDTH-1];
         sign_b <= ~op[0] & b[WIDTH-1];
         b_zero <= (b == '0);
         a_orig <= a;
         opnd   <= op[1] ? abs_b : abs_a;
         acc_hi <= '0;
         acc_lo <= op[1] ? abs_a : abs_b;
      end else if (state == ST_CALC) begin
         if (op_q[1]) begin
            acc_hi <= div_ok ? div_rem : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
         end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
         end
      end
   end

   // Control FSM and architectural HI/LO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  cnt      <= '0;
                  state    <= ST_CALC;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            ST_CALC: begin
               cnt <= cnt + 1'b1;
               if (cnt == CALC_CNT_W'(WIDTH - 1)) state <= ST_FIX;
            end
            ST_FIX: begin
               if (op_q[1]) begin
                  if (b_zero) begin
                     hi       <= a_orig;
                     lo       <= '1;
                     div_zero <= 1'b1;
                  end else begin
                     hi <= rem_fixed;
                     lo <= quot_fixed;
                  end
               end else begin
                  hi <= prod_fixed[2*WIDTH-1:WIDTH];
                  lo <= prod_fixed[WIDTH-1:0];
               end
               state <= ST_DONE;
            end
            ST_DONE: begin
               // done is registered here, so the pulse appears in the cycle
               // after DONE, alongside the first cycle a new start is taken.
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_muldiv_unit.sv
// Directed bench for mc_muldiv_unit (WIDTH=32).
module tb_mc_muldiv_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int compared   = 0;
   int mismatched = 0;

   int done_at;
   int busy_cnt;
   int done_cnt;
   int extra_done;

   mc_muldiv_unit #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .hi_we    (hi_we),
      .lo_we    (lo_we),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and watch 40 cycles after the accepting edge E0.
   // Cycle k is the cycle following edge E0+k. Optionally pulses start or
   // hi_we during the run at the given k (-1 disables).
   task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int inj_start_k, input int inj_we_k,
                        output int d_at, output int b_cnt, output int d_cnt);
      d_at  = -1;
      b_cnt = 0;
      d_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1; op = o; a = av; b = bv;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busy) b_cnt++;
         if (done) begin
            d_cnt++;
            if (d_at < 0) d_at = k;
         end
         start = (k == inj_start_k);
         hi_we = (k == inj_we_k);
         wdata = 32'hDEAD_BEEF;
         @(posedge clk); #1;
      end
      start = 1'b0;
      hi_we = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      hi_we = 1'b0;
      lo_we = 1'b0;
      wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dz",   64'(div_zero), 64'd0);
      check("rst_hi",   64'(hi), 64'd0);
      check("rst_lo",   64'(lo), 64'd0);
      reset = 1'b1;

      // MULT -3 * 7 = -21, with latency and busy width
      do_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, -1, done_at, busy_cnt, done_cnt);
      check("mult_done_at",  64'(done_at), 64'd34);
      check("mult_busy_cnt", 64'(busy_cnt), 64'd34);
      check("mult_done_cnt", 64'(done_cnt), 64'd1);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFEB);

      // MULTU max * max
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, done_at, busy_cnt, done_cnt);
      check("multu_done_at", 64'(done_at), 64'd34);
      check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
      check("multu_lo", 64'(lo), 64'h0000_0001);

      // DIV -7 / 2 = -3 rem -1
      do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, done_at, busy_cnt, done_cnt);
      check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
      check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

      // DIV overflow -2^31 / -1
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, done_at, busy_cnt, done_cnt);
      check("div_ovf_lo", 64'(lo), 64'h8000_0000);
      check("div_ovf_hi", 64'(hi), 64'h0);
      check("div_ovf_dz", 64'(div_zero), 64'd0);

      // DIVU by zero
      do_op(2'b11, 32'd100, 32'd0, -1, -1, done_at, busy_cnt, done_cnt);
      check("divz_done_at", 64'(done_at), 64'd34);
      check("divz_lo", 64'(lo), 64'hFFFF_FFFF);
      check("divz_hi", 64'(hi), 64'h0000_0064);
      check("divz_dz", 64'(div_zero), 64'd1);

      // MULTU 3*5 with a stray start and MTHI while busy
      do_op(2'b01, 32'd3, 32'd5, 5, 6, done_at, busy_cnt, done_cnt);
      check("inj_dz_clr",   64'(div_zero), 64'd0);
      check("inj_done_cnt", 64'(done_cnt), 64'd1);
      check("inj_done_at",  64'(done_at), 64'd34);
      check("inj_hi", 64'(hi), 64'h0);
      check("inj_lo", 64'(lo), 64'd15);

      // MTHI in IDLE
      @(posedge clk); #1;
      hi_we = 1'b1; wdata = 32'h0000_1234;
      @(posedge clk); #1;
      hi_we = 1'b0;
      check("mthi_hi", 64'(hi), 64'h0000_1234);
      check("mthi_lo", 64'(lo), 64'd15);

      // MTLO in IDLE
      lo_we = 1'b1; wdata = 32'h0000_5555;
      @(posedge clk); #1;
      lo_we = 1'b0;
      check("mtlo_hi", 64'(hi), 64'h0000_1234);
      check("mtlo_lo", 64'(lo), 64'h0000_5555);

      // Both together
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_ABCD;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      check("mtboth_hi", 64'(hi), 64'h0000_ABCD);
      check("mtboth_lo", 64'(lo), 64'h0000_ABCD);

      // Abort DIV 100/7 with an asynchronous reset mid-operation
      @(posedge clk); #1;
      start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #4;
      reset = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi",   64'(hi), 64'h0);
      check("abort_lo",   64'(lo), 64'h0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      extra_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) extra_done++;
      end
      check("abort_no_done", 64'(extra_done), 64'd0);

      // DIVU 100/7 after recovery
      do_op(2'b11, 32'd100, 32'd7, -1, -1, done_at, busy_cnt, done_cnt);
      check("divu_done_at", 64'(done_at), 64'd34);
      check("divu_lo", 64'(lo), 64'd14);
      check("divu_hi", 64'(hi), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
